// File: rtl/lcd_refresh_sequencer_if.sv
// lcd_refresh_sequencer_if: host and LCD-controller signal bundle for the refresh sequencer
// Host side: wr_en/wr_addr/wr_data frame writes, refresh_req pulse, busy/done/error status.
// Controller side: lcd_cmd/lcd_enable/lcd_data command out, lcd_rdy handshake in.
// master = environment (host + controller), slave = sequencer.
interface lcd_refresh_sequencer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh_req;
  logic       busy;
  logic       done;
  logic       error;
  logic [5:0] lcd_cmd;
  logic       lcd_enable;
  logic [7:0] lcd_data;
  logic       lcd_rdy;
  modport master (output wr_en, wr_addr, wr_data, refresh_req, lcd_rdy,
                  input busy, done, error, lcd_cmd, lcd_enable, lcd_data);
  modport slave (input wr_en, wr_addr, wr_data, refresh_req, lcd_rdy,
                 output busy, done, error, lcd_cmd, lcd_enable, lcd_data);
endinterface

// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer: paints a 32-byte host frame buffer onto an LCD 1602A via its command controller
// Ports: clk; rst (sync, active-high); bus (slave) carrying host writes/refresh/status and the
// one-command-at-a-time controller handshake (lcd_cmd, lcd_enable, lcd_data, lcd_rdy).
module lcd_refresh_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20,
  parameter logic [7:0] PAD_CHAR       = 8'h20,
  parameter bit         AUTO_INIT      = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  lcd_refresh_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_WAIT, S_RELEASE, S_FINISH} state_t;
  typedef enum logic [2:0] {P_INIT, P_CLEAR, P_LINE1, P_PAD, P_LINE2} phase_t;
  localparam logic [5:0] CMD_INIT = 6'd1, CMD_DATA = 6'd3, CMD_CLEAR = 6'd4;
  state_t          r_state, w_next;
  phase_t          r_phase, w_phase;
  logic [4:0]      r_idx, w_idx;
  logic [TO_W-1:0] r_to;
  logic [7:0]      r_buf [32];
  logic [5:0]      r_cmd;
  logic [7:0]      r_data;
  logic            r_init_ok, r_pending, r_error, r_auto;
  logic            w_to, w_abort, w_consume, w_init_done, w_start, w_accept, w_en;
  logic [7:0]      w_byte;
  assign w_to     = r_to == TO_W'(TIMEOUT_CYCLES - 1);
  assign w_start  = w_next == S_ASSERT && r_state != S_ASSERT;
  assign w_accept = r_state == S_IDLE && bus.refresh_req;
  assign w_en     = r_state == S_ASSERT || r_state == S_WAIT;
  // line 2 characters live in the upper half of the buffer
  assign w_byte   = r_buf[{w_phase == P_LINE2, w_idx[3:0]}];
  always_comb begin
    w_next      = r_state;
    w_phase     = r_phase;
    w_idx       = r_idx;
    w_abort     = 1'b0;
    w_consume   = 1'b0;
    w_init_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.refresh_req || r_auto) begin
        w_next  = S_ASSERT;
        w_phase = r_init_ok ? P_CLEAR : P_INIT;
        w_idx   = '0;
      end
      S_ASSERT: begin
        w_abort = w_to && bus.lcd_rdy;
        w_next  = !bus.lcd_rdy ? S_WAIT : w_to ? S_IDLE : S_ASSERT;
      end
      S_WAIT: begin
        w_abort = w_to && !bus.lcd_rdy;
        w_next  = bus.lcd_rdy ? S_RELEASE : w_to ? S_IDLE : S_WAIT;
      end
      S_RELEASE: begin
        w_next = S_ASSERT;
        w_idx  = r_idx + 5'd1;
        case (r_phase)
          P_INIT: begin
            w_init_done = 1'b1;
            w_consume   = r_pending;
            w_next      = r_pending ? S_ASSERT : S_IDLE;
            w_phase     = P_CLEAR;
            w_idx       = '0;
          end
          P_CLEAR: begin
            w_phase = P_LINE1;
            w_idx   = '0;
          end
          P_LINE1: if (r_idx == 5'd15) begin
            w_phase = P_PAD;
            w_idx   = '0;
          end
          P_PAD: if (r_idx == 5'd23) begin
            w_phase = P_LINE2;
            w_idx   = '0;
          end
          default: if (r_idx == 5'd15) w_next = S_FINISH;
        endcase
      end
      S_FINISH: begin
        // a request landing on the finish cycle chains straight into the next frame
        w_consume = r_pending || bus.refresh_req;
        w_next    = w_consume ? S_ASSERT : S_IDLE;
        w_phase   = P_CLEAR;
        w_idx     = '0;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= P_INIT;
      r_idx     <= '0;
      r_to      <= '0;
      r_cmd     <= '0;
      r_data    <= '0;
      r_init_ok <= 1'b0;
      r_pending <= 1'b0;
      r_error   <= 1'b0;
      r_auto    <= AUTO_INIT;
      for (int i = 0; i < 32; i++) r_buf[i] <= PAD_CHAR;
    end else begin
      if (bus.wr_en) r_buf[bus.wr_addr] <= bus.wr_data;
      r_to <= (w_next != r_state) ? '0 : r_to + TO_W'(1);
      if (w_start) begin
        r_phase <= w_phase;
        r_idx   <= w_idx;
        r_cmd   <= w_phase == P_INIT ? CMD_INIT : w_phase == P_CLEAR ? CMD_CLEAR : CMD_DATA;
        r_data  <= (w_phase == P_INIT || w_phase == P_CLEAR) ? 8'h00 : w_phase == P_PAD ? PAD_CHAR : w_byte;
      end
      if (w_start && w_phase == P_INIT) r_auto <= 1'b0;
      if (w_init_done) r_init_ok <= 1'b1;
      r_pending <= !w_abort && ((r_pending && !w_consume) ||
                   (bus.refresh_req && r_state != S_IDLE && r_state != S_FINISH) ||
                   (w_accept && !r_init_ok));
      r_error <= w_abort || (r_error && !w_accept);
    end
  end
  assign bus.busy       = r_state != S_IDLE && r_state != S_FINISH;
  assign bus.done       = r_state == S_FINISH;
  assign bus.error      = r_error;
  assign bus.lcd_enable = w_en;
  assign bus.lcd_cmd    = w_en ? r_cmd : '0;
  assign bus.lcd_data   = r_data;
endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb_lcd_refresh_sequencer: directed checks of the LCD refresh sequencer against a controller model
module tb_lcd_refresh_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  lcd_refresh_sequencer_if bus();
  lcd_refresh_sequencer #(.TIMEOUT_CYCLES(100), .TO_W(8), .PAD_CHAR(8'h20), .AUTO_INIT(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int pos; logic [5:0] cmd; logic [7:0] data; } exp_t;
  wr_t  wtab [10];
  exp_t etab [16];
  logic [7:0]  mbuf [32];
  logic [13:0] log_q [$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, cyc = 0;
  logic prev_en = 1'b0;
  logic m_rdy = 1'b1, m_acc = 1'b0;
  int   m_cnt = 0, stall_at = 0;
  bit   stall = 1'b0;
  assign bus.lcd_rdy = m_rdy;
  // controller: rdy falls one cycle after enable, rises 3 cycles later, resets when enable drops
  always @(posedge clk) begin
    if (rst || !bus.lcd_enable) begin
      m_rdy <= 1'b1; m_acc <= 1'b0; m_cnt <= 0;
    end else if (!m_acc) begin
      if (!(stall && log_q.size() == stall_at)) begin
        m_rdy <= 1'b0; m_acc <= 1'b1; m_cnt <= 3;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_rdy <= 1'b1;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (bus.done) done_cnt++;
    if (bus.lcd_enable && !prev_en) log_q.push_back({bus.lcd_cmd, bus.lcd_data});
    prev_en = bus.lcd_enable;
  end
  task automatic step();
    @(negedge clk); #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [13:0] entry(input int i);
    return i < log_q.size() ? log_q[i] : 14'h3fff;
  endfunction
  function automatic logic [13:0] exp_entry(input int i);
    if (i == 0) return {6'd4, 8'h00};
    if (i <= 16) return {6'd3, mbuf[i-1]};
    if (i <= 40) return {6'd3, 8'h20};
    return {6'd3, mbuf[i-25]};
  endfunction
  task automatic check_frame(input int off, input string nm);
    chk({nm, " len"}, (log_q.size() >= off + 57) ? 1 : 0, 1);
    for (int i = 0; i < 57; i++) chk($sformatf("%s cmd%0d", nm, i), entry(off + i), exp_entry(i));
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; mbuf[a] = d;
    step();
    bus.wr_en = 1'b0;
  endtask
  task automatic req();
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
  endtask
  task automatic wait_done(input int n, input string nm);
    int k = 0;
    while (done_cnt < n && k < 3000) begin step(); k++; end
    chk(nm, done_cnt, n);
  endtask
  task automatic wait_log(input int n, input string nm);
    int k = 0;
    while (log_q.size() < n && k < 2000) begin step(); k++; end
    chk(nm, log_q.size(), n);
  endtask
  task automatic wait_busy(input logic v, input string nm);
    int k = 0;
    while (bus.busy !== v && k < 500) begin step(); k++; end
    chk(nm, bus.busy, v);
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " done"}, bus.done, 0);
    chk({nm, " err"}, bus.error, 0);
    chk({nm, " cmd"}, bus.lcd_cmd, 0);
    chk({nm, " en"}, bus.lcd_enable, 0);
    chk({nm, " data"}, bus.lcd_data, 0);
  endtask
  initial begin
    int base, t0, k;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.refresh_req = 1'b0;
    foreach (mbuf[i]) mbuf[i] = 8'h20;
    wtab = '{'{5'd0, 8'h48}, '{5'd1, 8'h45}, '{5'd2, 8'h4C}, '{5'd3, 8'h4C}, '{5'd4, 8'h4F},
             '{5'd16, 8'h57}, '{5'd17, 8'h4F}, '{5'd18, 8'h52}, '{5'd19, 8'h4C}, '{5'd20, 8'h44}};
    etab = '{'{0, 6'd4, 8'h00}, '{1, 6'd3, 8'h48}, '{2, 6'd3, 8'h45}, '{3, 6'd3, 8'h4C},
             '{4, 6'd3, 8'h4C}, '{5, 6'd3, 8'h4F}, '{6, 6'd3, 8'h20}, '{17, 6'd3, 8'h20},
             '{40, 6'd3, 8'h20}, '{41, 6'd3, 8'h57}, '{42, 6'd3, 8'h4F}, '{43, 6'd3, 8'h52},
             '{44, 6'd3, 8'h4C}, '{45, 6'd3, 8'h44}, '{46, 6'd3, 8'h20}, '{56, 6'd3, 8'h20}};
    // 1: reset state and automatic INIT
    repeat (3) step();
    chk_quiet("reset");
    rst = 1'b0;
    wait_busy(1'b1, "init busy rise");
    wait_busy(1'b0, "init busy fall");
    chk("init cmds", log_q.size(), 1);
    chk("init cmd", entry(0), {6'd1, 8'h00});
    chk("init no done", done_cnt, 0);
    // 2: HELLO / WORLD frame
    foreach (wtab[i]) wr(wtab[i].addr, wtab[i].data);
    log_q.delete();
    base = done_cnt;
    req();
    wait_done(base + 1, "frame done");
    repeat (5) step();
    chk("frame one done", done_cnt, base + 1);
    chk("frame idle", bus.busy, 0);
    foreach (etab[i]) chk($sformatf("trace pos%0d", etab[i].pos), entry(etab[i].pos), {etab[i].cmd, etab[i].data});
    check_frame(0, "frame");
    // 3: controller never accepts command 10 -> timeout
    log_q.delete();
    stall = 1'b1; stall_at = 10;
    base = done_cnt;
    req();
    wait_log(10, "stall reach");
    t0 = cyc; k = 0;
    while (bus.error !== 1'b1 && k < 300) begin step(); k++; end
    chk("to error", bus.error, 1);
    chk("to latency", cyc - t0, 100);
    chk("to en", bus.lcd_enable, 0);
    chk("to cmd", bus.lcd_cmd, 0);
    chk("to busy", bus.busy, 0);
    repeat (5) step();
    chk("to no done", done_cnt, base);
    stall = 1'b0;
    log_q.delete();
    req();
    chk("retry err clr", bus.error, 0);
    chk("retry busy", bus.busy, 1);
    wait_done(base + 1, "retry done");
    check_frame(0, "retry");
    // 4: two requests while busy merge into one follow-on frame
    log_q.delete();
    base = done_cnt;
    req();
    wait_log(20, "merge mid");
    req();
    repeat (3) step();
    req();
    wait_done(base + 2, "merge done");
    repeat (200) step();
    chk("merge total", done_cnt, base + 2);
    chk("merge cmds", log_q.size(), 114);
    chk("merge clear", entry(57), {6'd4, 8'h00});
    // request on the FINISH cycle itself
    log_q.delete();
    base = done_cnt;
    req();
    k = 0;
    while (bus.done !== 1'b1 && k < 1000) begin step(); k++; end
    chk("fin seen", bus.done, 1);
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    wait_done(base + 2, "fin chain");
    chk("fin cmds", log_q.size(), 114);
    chk("fin clear", entry(57), {6'd4, 8'h00});
    // 5: writes while idx 5 is in flight
    log_q.delete();
    base = done_cnt;
    req();
    wait_log(7, "mid line1");
    wr(5'd0, 8'h58);
    wr(5'd31, 8'h5A);
    wait_done(base + 1, "mid done");
    chk("mid idx0 old", entry(1), {6'd3, 8'h48});
    chk("mid idx31 new", entry(56), {6'd3, 8'h5A});
    // 6: reset during PAD
    log_q.delete();
    req();
    wait_log(25, "pad reach");
    rst = 1'b1;
    step();
    chk_quiet("midrst");
    foreach (mbuf[i]) mbuf[i] = 8'h20;
    log_q.delete();
    base = done_cnt;
    step();
    rst = 1'b0;
    wait_log(1, "reinit start");
    wait_busy(1'b0, "reinit end");
    chk("reinit cmds", log_q.size(), 1);
    chk("reinit cmd", entry(0), {6'd1, 8'h00});
    chk("reinit no done", done_cnt, base);
    log_q.delete();
    req();
    wait_done(base + 1, "blank done");
    check_frame(0, "blank");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
